// File: rtl/escalonador_demux4way16_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : escalonador_demux4way16_pkg                                      |
// | Brief  : Shared widths, output-state encoding and FIFO entry layout.     |
// | Rev    : 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
package escalonador_demux4way16_pkg;

    localparam int c_NUM_CANAIS = 4;
    localparam int c_DATA_W     = 16;
    localparam int c_DEST_W     = 2;

    typedef enum logic [0:0] {
        VAZIO     = 1'b0,
        APRESENTA = 1'b1
    } estado_t;

    typedef struct packed {
        logic [c_DEST_W-1:0] dest;
        logic [c_DATA_W-1:0] data;
    } entrada_t;

endpackage
`default_nettype wire

// File: rtl/escalonador_demux4way16_fila.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : fila_demux                                                      |
// | Brief  : Synchronous FIFO with push/pop, flush, full/empty and count.    |
// | Rev    : 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module fila_demux #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 18
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int            c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0] c_FULL = (c_AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign full    = (r_count == c_FULL);
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign rd_data = r_mem[r_rd_ptr];
    assign w_push  = push && !full;
    assign w_pop   = pop && !empty;

    // DEPTH is a power of two, so the pointers wrap on their own overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= wr_data;
    end

endmodule
`default_nettype wire

// File: rtl/escalonador_demux4way16.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : escalonador_demux4way16                                         |
// | Brief  : Buffered 4-way router with one-hot output stage and counters.   |
// | Rev    : 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module escalonador_demux4way16
    import escalonador_demux4way16_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic [1:0]       in_dest,
    input  logic             flush,
    input  logic             clr_cnt,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [15:0]      canal0,
    output logic [15:0]      canal1,
    output logic [15:0]      canal2,
    output logic [15:0]      canal3,
    output logic             ocupado,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
    output logic [CNT_W-1:0] cnt3
);

    localparam int c_CW = $clog2(DEPTH) + 1;

    entrada_t                w_entrada;
    entrada_t                w_cabeca;
    logic                    w_full;
    logic                    w_empty;
    logic [c_CW-1:0]         w_fifo_count;
    logic [c_CW-1:0]         w_count_prox;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_transfer;
    estado_t                 r_estado;
    estado_t                 w_estado_prox;
    entrada_t                r_saida;
    entrada_t                w_saida_prox;
    logic [c_NUM_CANAIS-1:0] r_out_valid;
    logic [c_NUM_CANAIS-1:0] w_out_valid_prox;
    logic                    r_ocupado;
    logic                    w_ocupado_prox;

    assign w_entrada.dest = in_dest;
    assign w_entrada.data = in_data;

    // No pass-through: a full FIFO refuses input even while it is popping.
    assign in_ready   = !reset && !w_full && !flush;
    assign w_push     = in_valid && in_ready;
    assign w_transfer = |(r_out_valid & out_ready);
    assign w_pop      = !flush && !w_empty && ((r_estado == VAZIO) || w_transfer);

    fila_demux #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(entrada_t))
    ) u_fila (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .push    (w_push),
        .pop     (w_pop),
        .wr_data (w_entrada),
        .rd_data (w_cabeca),
        .full    (w_full),
        .empty   (w_empty),
        .count   (w_fifo_count)
    );

    always_comb begin
        w_count_prox = w_fifo_count;
        if (flush)                 w_count_prox = '0;
        else if (w_push && !w_pop) w_count_prox = w_fifo_count + 1'b1;
        else if (!w_push && w_pop) w_count_prox = w_fifo_count - 1'b1;
    end

    // Next output-stage state; out_valid and ocupado are precomputed so they leave registers.
    always_comb begin
        w_estado_prox    = r_estado;
        w_saida_prox     = r_saida;
        w_out_valid_prox = '0;
        if (flush) begin
            w_estado_prox = VAZIO;
        end else if (w_pop) begin
            w_estado_prox = APRESENTA;
            w_saida_prox  = w_cabeca;
        end else if (w_transfer) begin
            w_estado_prox = VAZIO;
        end
        if (w_estado_prox == APRESENTA) w_out_valid_prox[w_saida_prox.dest] = 1'b1;
        w_ocupado_prox = (w_count_prox != '0) || (w_estado_prox == APRESENTA);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_estado    <= VAZIO;
            r_saida     <= '0;
            r_out_valid <= '0;
            r_ocupado   <= 1'b0;
        end else begin
            r_estado    <= w_estado_prox;
            r_saida     <= w_saida_prox;
            r_out_valid <= w_out_valid_prox;
            r_ocupado   <= w_ocupado_prox;
        end
    end

    for (genvar d = 0; d < c_NUM_CANAIS; d++) begin : g_canal
        logic [CNT_W-1:0]    r_cnt;
        logic [c_DATA_W-1:0] w_canal;

        assign w_canal = r_out_valid[d] ? r_saida.data : '0;

        // Clear wins over a same-cycle increment; the count saturates at all-ones.
        always_ff @(posedge clk or posedge reset) begin
            if (reset)                                        r_cnt <= '0;
            else if (clr_cnt)                                 r_cnt <= '0;
            else if (r_out_valid[d] && out_ready[d] && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
        end
    end

    assign out_valid = r_out_valid;
    assign ocupado   = r_ocupado;
    assign canal0    = g_canal[0].w_canal;
    assign canal1    = g_canal[1].w_canal;
    assign canal2    = g_canal[2].w_canal;
    assign canal3    = g_canal[3].w_canal;
    assign cnt0      = g_canal[0].r_cnt;
    assign cnt1      = g_canal[1].r_cnt;
    assign cnt2      = g_canal[2].r_cnt;
    assign cnt3      = g_canal[3].r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_escalonador_demux4way16.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_escalonador_demux4way16                                      |
// | Brief  : Directed table-driven bench for the 4-way buffered router.      |
// | Rev    : 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module tb_escalonador_demux4way16;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [1:0]  in_dest;
    logic        flush;
    logic        clr_cnt;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [15:0] canal0, canal1, canal2, canal3;
    logic        ocupado;
    logic [7:0]  cnt0, cnt1, cnt2, cnt3;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    escalonador_demux4way16 #(.DEPTH(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_dest(in_dest), .flush(flush), .clr_cnt(clr_cnt),
        .out_valid(out_valid), .out_ready(out_ready),
        .canal0(canal0), .canal1(canal1), .canal2(canal2), .canal3(canal3),
        .ocupado(ocupado), .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
    );

    typedef struct {
        logic        vld;
        logic [1:0]  dest;
        logic [15:0] data;
        logic [3:0]  ordy;
        logic        fl;
        logic        clr;
        logic        exp_ir;
        logic [3:0]  exp_ov;
        logic [15:0] exp_dat;
        logic        exp_ocu;
        logic [7:0]  exp_c0, exp_c1, exp_c2, exp_c3;
    } vec_t;

    vec_t tbl[25];

    function automatic vec_t mk(input logic v, input logic [1:0] d, input logic [15:0] dat,
                                input logic [3:0] r, input logic f, input logic c,
                                input logic ir, input logic [3:0] ov, input logic [15:0] ed,
                                input logic ocu, input logic [7:0] c0, input logic [7:0] c1,
                                input logic [7:0] c2, input logic [7:0] c3);
        vec_t x;
        x.vld = v; x.dest = d; x.data = dat; x.ordy = r; x.fl = f; x.clr = c;
        x.exp_ir = ir; x.exp_ov = ov; x.exp_dat = ed; x.exp_ocu = ocu;
        x.exp_c0 = c0; x.exp_c1 = c1; x.exp_c2 = c2; x.exp_c3 = c3;
        return x;
    endfunction

    task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nome, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_canais(input string tag, input logic [3:0] ov, input logic [15:0] dat);
        chk({tag, " canal0"}, {16'h0, canal0}, {16'h0, ov[0] ? dat : 16'h0});
        chk({tag, " canal1"}, {16'h0, canal1}, {16'h0, ov[1] ? dat : 16'h0});
        chk({tag, " canal2"}, {16'h0, canal2}, {16'h0, ov[2] ? dat : 16'h0});
        chk({tag, " canal3"}, {16'h0, canal3}, {16'h0, ov[3] ? dat : 16'h0});
    endtask

    initial begin
        // single word to channel 2
        tbl[0]  = mk(1, 2, 16'hBEEF, 4'hF, 0, 0, 1, 4'b0000, 16'h0000, 1, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 16'h0000, 4'hF, 0, 0, 1, 4'b0100, 16'hBEEF, 1, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 16'h0000, 4'hF, 0, 0, 1, 4'b0000, 16'h0000, 0, 0, 0, 1, 0);
        // back-pressure fill, full refusal during a pop, ordered drain
        tbl[3]  = mk(1, 0, 16'h00A1, 4'h0, 0, 0, 1, 4'b0000, 16'h0000, 1, 0, 0, 1, 0);
        tbl[4]  = mk(1, 1, 16'h00B2, 4'h0, 0, 0, 1, 4'b0001, 16'h00A1, 1, 0, 0, 1, 0);
        tbl[5]  = mk(1, 3, 16'h00C3, 4'h0, 0, 0, 1, 4'b0001, 16'h00A1, 1, 0, 0, 1, 0);
        tbl[6]  = mk(1, 0, 16'h00D4, 4'h0, 0, 0, 1, 4'b0001, 16'h00A1, 1, 0, 0, 1, 0);
        tbl[7]  = mk(1, 2, 16'h00E5, 4'h0, 0, 0, 1, 4'b0001, 16'h00A1, 1, 0, 0, 1, 0);
        tbl[8]  = mk(1, 3, 16'h00F6, 4'hF, 0, 0, 0, 4'b0010, 16'h00B2, 1, 1, 0, 1, 0);
        tbl[9]  = mk(0, 0, 16'h0000, 4'hF, 0, 0, 1, 4'b1000, 16'h00C3, 1, 1, 1, 1, 0);
        tbl[10] = mk(0, 0, 16'h0000, 4'hF, 0, 0, 1, 4'b0001, 16'h00D4, 1, 1, 1, 1, 1);
        tbl[11] = mk(0, 0, 16'h0000, 4'hF, 0, 0, 1, 4'b0100, 16'h00E5, 1, 2, 1, 1, 1);
        tbl[12] = mk(0, 0, 16'h0000, 4'hF, 0, 0, 1, 4'b0000, 16'h0000, 0, 2, 1, 2, 1);
        // ready on the wrong channels is ignored
        tbl[13] = mk(1, 1, 16'h1234, 4'hD, 0, 0, 1, 4'b0000, 16'h0000, 1, 2, 1, 2, 1);
        tbl[14] = mk(0, 0, 16'h0000, 4'hD, 0, 0, 1, 4'b0010, 16'h1234, 1, 2, 1, 2, 1);
        tbl[15] = mk(0, 0, 16'h0000, 4'hD, 0, 0, 1, 4'b0010, 16'h1234, 1, 2, 1, 2, 1);
        tbl[16] = mk(0, 0, 16'h0000, 4'h2, 0, 0, 1, 4'b0000, 16'h0000, 0, 2, 2, 2, 1);
        // flush with 3 queued + 1 presented; presented word completes on the flush edge
        tbl[17] = mk(1, 0, 16'h0011, 4'h0, 0, 0, 1, 4'b0000, 16'h0000, 1, 2, 2, 2, 1);
        tbl[18] = mk(1, 1, 16'h0022, 4'h0, 0, 0, 1, 4'b0001, 16'h0011, 1, 2, 2, 2, 1);
        tbl[19] = mk(1, 2, 16'h0033, 4'h0, 0, 0, 1, 4'b0001, 16'h0011, 1, 2, 2, 2, 1);
        tbl[20] = mk(1, 3, 16'h0044, 4'h0, 0, 0, 1, 4'b0001, 16'h0011, 1, 2, 2, 2, 1);
        tbl[21] = mk(1, 2, 16'h0055, 4'h1, 1, 0, 0, 4'b0000, 16'h0000, 0, 3, 2, 2, 1);
        tbl[22] = mk(1, 2, 16'h0066, 4'hF, 0, 0, 1, 4'b0000, 16'h0000, 1, 3, 2, 2, 1);
        tbl[23] = mk(0, 0, 16'h0000, 4'hF, 0, 0, 1, 4'b0100, 16'h0066, 1, 3, 2, 2, 1);
        tbl[24] = mk(0, 0, 16'h0000, 4'hF, 0, 0, 1, 4'b0000, 16'h0000, 0, 3, 2, 3, 1);

        reset = 1'b1; in_valid = 0; in_data = '0; in_dest = '0;
        flush = 0; clr_cnt = 0; out_ready = '0;
        #12;
        chk("reset out_valid", {28'h0, out_valid}, 32'h0);
        chk("reset in_ready", {31'h0, in_ready}, 32'h0);
        chk("reset ocupado", {31'h0, ocupado}, 32'h0);
        chk_canais("reset", 4'b0000, 16'h0);
        chk("reset cnts", {cnt3, cnt2, cnt1, cnt0}, 32'h0);
        #4 reset = 1'b0;
        tick();

        for (int i = 0; i < 25; i++) begin
            string tag;
            tag = $sformatf("row%0d", i);
            in_valid = tbl[i].vld; in_dest = tbl[i].dest; in_data = tbl[i].data;
            out_ready = tbl[i].ordy; flush = tbl[i].fl; clr_cnt = tbl[i].clr;
            #1;
            chk({tag, " in_ready"}, {31'h0, in_ready}, {31'h0, tbl[i].exp_ir});
            @(posedge clk);
            #1;
            chk({tag, " out_valid"}, {28'h0, out_valid}, {28'h0, tbl[i].exp_ov});
            chk_canais(tag, tbl[i].exp_ov, tbl[i].exp_dat);
            chk({tag, " ocupado"}, {31'h0, ocupado}, {31'h0, tbl[i].exp_ocu});
            chk({tag, " cnts"}, {cnt3, cnt2, cnt1, cnt0},
                {tbl[i].exp_c3, tbl[i].exp_c2, tbl[i].exp_c1, tbl[i].exp_c0});
        end
        in_valid = 0; flush = 0; clr_cnt = 0;

        // 260 back-to-back transfers on channel 3: starts at 1, must saturate at 255
        out_ready = 4'hF;
        for (int i = 0; i < 260; i++) begin
            in_valid = 1; in_dest = 2'd3; in_data = 16'(i);
            #1;
            chk($sformatf("sat push%0d in_ready", i), {31'h0, in_ready}, 32'h1);
            @(posedge clk);
            #1;
        end
        in_valid = 0;
        tick(); tick(); tick();
        chk("sat cnt3", {24'h0, cnt3}, 32'd255);
        chk("sat other cnts", {8'h0, cnt2, cnt1, cnt0}, {8'h0, 8'd3, 8'd2, 8'd3});
        chk("sat ocupado", {31'h0, ocupado}, 32'h0);

        // asynchronous reset while streaming to channel 1
        in_valid = 1; in_dest = 2'd1; in_data = 16'h5A5A;
        tick(); tick();
        chk("stream out_valid", {28'h0, out_valid}, 32'h2);
        #3 reset = 1'b1;
        #1;
        chk("async out_valid", {28'h0, out_valid}, 32'h0);
        chk("async canal1", {16'h0, canal1}, 32'h0);
        chk("async ocupado", {31'h0, ocupado}, 32'h0);
        chk("async in_ready", {31'h0, in_ready}, 32'h0);
        chk("async cnts", {cnt3, cnt2, cnt1, cnt0}, 32'h0);
        in_valid = 0;
        @(posedge clk);
        #3 reset = 1'b0;
        tick();

        // two-edge latency after reset release
        in_valid = 1; in_dest = 2'd3; in_data = 16'h0ABC;
        tick();
        in_valid = 0;
        chk("lat edge1 out_valid", {28'h0, out_valid}, 32'h0);
        chk("lat edge1 ocupado", {31'h0, ocupado}, 32'h1);
        tick();
        chk("lat edge2 out_valid", {28'h0, out_valid}, 32'h8);
        chk("lat edge2 canal3", {16'h0, canal3}, 32'h0ABC);

        // clear coinciding with a transfer wins
        clr_cnt = 1;
        tick();
        clr_cnt = 0;
        chk("clr cnt3", {24'h0, cnt3}, 32'h0);
        chk("clr out_valid", {28'h0, out_valid}, 32'h0);
        tick();
        chk("clr hold cnts", {cnt3, cnt2, cnt1, cnt0}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
